// File: rtl/sram_read_port_ctrl_if.sv
// sram_read_port_ctrl_if: read-request, write and read-response channels of sram_read_port_ctrl.
interface sram_read_port_ctrl_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int MASK_WIDTH = 4
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  wr_valid;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [MASK_WIDTH-1:0] wr_mask;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_data;
   modport master (
      output req_valid, req_addr, wr_valid, wr_addr, wr_data, wr_mask, resp_ready,
      input  req_ready, resp_valid, resp_data
   );
   modport slave (
      input  req_valid, req_addr, wr_valid, wr_addr, wr_data, wr_mask, resp_ready,
      output req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/sram_read_port_ctrl.sv
// sram_read_port_ctrl: valid/ready read front-end for a 1R1W SRAM macro with a 2-entry response buffer
// and same-cycle write-to-read forwarding.
module sram_read_port_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int MASK_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   sram_read_port_ctrl_if.slave  bus,
   output logic                  sram_R0_en,
   output logic [ADDR_WIDTH-1:0] sram_R0_addr,
   input  logic [DATA_WIDTH-1:0] sram_R0_data,
   output logic                  sram_W0_en,
   output logic [ADDR_WIDTH-1:0] sram_W0_addr,
   output logic [DATA_WIDTH-1:0] sram_W0_data,
   output logic [MASK_WIDTH-1:0] sram_W0_mask,
   output logic [15:0]           fwd_count
);
   logic [DATA_WIDTH-1:0] fifo [2];
   logic                  wp;
   logic                  rp;
   logic [1:0]            count;
   logic                  inflight;
   logic                  hit;
   logic [DATA_WIDTH-1:0] hit_data;
   logic [MASK_WIDTH-1:0] hit_mask;
   logic [DATA_WIDTH-1:0] cap;
   logic [1:0]            occupancy;
   logic                  fire_req;
   logic                  collide;
   logic                  empty;
   logic                  push;
   logic                  pop;

   // Readiness depends only on registered occupancy, never on resp_ready.
   assign occupancy     = count + {1'b0, inflight};
   assign bus.req_ready = !reset && occupancy < 2'd2;
   assign fire_req      = bus.req_valid && bus.req_ready;
   assign collide       = fire_req && bus.wr_valid && bus.wr_addr == bus.req_addr;

   assign sram_R0_en   = fire_req;
   assign sram_R0_addr = bus.req_addr;
   assign sram_W0_en   = bus.wr_valid && !reset;
   assign sram_W0_addr = bus.wr_addr;
   assign sram_W0_data = bus.wr_data;
   assign sram_W0_mask = bus.wr_mask;

   always_comb begin
      cap = sram_R0_data;
      for (int i = 0; i < MASK_WIDTH; i++)
         if (hit && hit_mask[i]) cap[8*i +: 8] = hit_data[8*i +: 8];
   end

   // An empty buffer lets the returning word fall straight through to the response.
   assign empty          = count == 2'd0;
   assign bus.resp_valid = !reset && (!empty || inflight);
   assign bus.resp_data  = empty ? cap : fifo[rp];
   assign pop            = bus.resp_valid && bus.resp_ready && !empty;
   assign push           = inflight && !(empty && bus.resp_ready);

   always_ff @(posedge clock) begin
      if (reset) begin
         count     <= 2'd0;
         wp        <= 1'b0;
         rp        <= 1'b0;
         inflight  <= 1'b0;
         hit       <= 1'b0;
         fwd_count <= 16'd0;
      end else begin
         count    <= count + {1'b0, push} - {1'b0, pop};
         wp       <= wp ^ push;
         rp       <= rp ^ pop;
         inflight <= fire_req;
         hit      <= collide;
         if (collide && fwd_count != 16'hFFFF) fwd_count <= fwd_count + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      hit_data <= bus.wr_data;
      hit_mask <= bus.wr_mask;
      if (push) fifo[wp] <= cap;
   end
endmodule

// File: tb/tb_sram_read_port_ctrl.sv
// tb_sram_read_port_ctrl: scoreboard bench for sram_read_port_ctrl with a behavioural 1R1W macro
// that returns old data on read-during-write.
module tb_sram_read_port_ctrl;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int MW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          sram_R0_en;
   logic [AW-1:0] sram_R0_addr;
   logic [DW-1:0] sram_R0_data;
   logic          sram_W0_en;
   logic [AW-1:0] sram_W0_addr;
   logic [DW-1:0] sram_W0_data;
   logic [MW-1:0] sram_W0_mask;
   logic [15:0]   fwd_count;
   logic [DW-1:0] sram [1024];
   logic [DW-1:0] model [1024];
   logic [DW-1:0] exp_q [$];
   logic [15:0]   fwd_exp = 16'd0;
   logic          hold_pending = 1'b0;
   logic [DW-1:0] hold_data;
   int            n_chk = 0;
   int            n_fail = 0;

   sram_read_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

   sram_read_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus),
      .sram_R0_en   (sram_R0_en),
      .sram_R0_addr (sram_R0_addr),
      .sram_R0_data (sram_R0_data),
      .sram_W0_en   (sram_W0_en),
      .sram_W0_addr (sram_W0_addr),
      .sram_W0_data (sram_W0_data),
      .sram_W0_mask (sram_W0_mask),
      .fwd_count    (fwd_count)
   );

   always #5 clock = ~clock;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [MW-1:0] m);
      merge = old;
      for (int i = 0; i < MW; i++) if (m[i]) merge[8*i +: 8] = nw[8*i +: 8];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Macro model: registered read address, read sees the word before a same-edge write.
   always @(posedge clock) begin
      if (sram_W0_en) sram[sram_W0_addr] <= merge(sram[sram_W0_addr], sram_W0_data, sram_W0_mask);
      if (sram_R0_en) sram_R0_data <= sram[sram_R0_addr];
   end

   // Scoreboard: a read expects the model word after this cycle's write is applied.
   always @(negedge clock) begin
      if (reset) begin
         exp_q.delete();
         fwd_exp = 16'd0;
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            check("resp_valid_hold", 32'(bus.resp_valid), 32'd1);
            check("resp_data_hold", bus.resp_data, hold_data);
         end
         if (bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) check("resp_expected", 32'(exp_q.size()), 32'd1);
            else check("resp_data", bus.resp_data, exp_q.pop_front());
         end
         hold_pending = bus.resp_valid && !bus.resp_ready;
         hold_data = bus.resp_data;
         if (bus.wr_valid) model[bus.wr_addr] = merge(model[bus.wr_addr], bus.wr_data, bus.wr_mask);
         if (bus.req_valid && bus.req_ready) begin
            exp_q.push_back(model[bus.req_addr]);
            if (bus.wr_valid && bus.wr_addr == bus.req_addr && fwd_exp != 16'hFFFF) fwd_exp++;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      bus.wr_mask  = m;
      tick();
      bus.wr_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      bus.req_valid  = 1'b0;
      bus.wr_valid   = 1'b0;
      bus.resp_ready = 1'b1;
      while (exp_q.size() != 0 && t < 100) begin
         tick();
         t++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      bus.req_valid  = 1'b1;
      bus.req_addr   = '0;
      bus.wr_valid   = 1'b1;
      bus.wr_addr    = AW'(5);
      bus.wr_data    = '1;
      bus.wr_mask    = '1;
      bus.resp_ready = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_r0_en", 32'(sram_R0_en), 32'd0);
      check("rst_w0_en", 32'(sram_W0_en), 32'd0);
      check("rst_fwd_count", 32'(fwd_count), 32'd0);
      tick();
      reset = 1'b0;
      bus.req_valid = 1'b0;
      bus.wr_valid  = 1'b0;
      @(negedge clock);
      check("rel_req_ready", 32'(bus.req_ready), 32'd1);
      tick();
      for (int i = 0; i < 16; i++) write(AW'(i), 32'h1000 + 32'(i), 4'hF);
      // Streaming: one request per cycle, one response per cycle.
      for (int i = 0; i < 8; i++) begin
         bus.req_valid = 1'b1;
         bus.req_addr  = AW'(i);
         @(negedge clock);
         check("stream_req_ready", 32'(bus.req_ready), 32'd1);
         if (i > 0) begin
            check("stream_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("stream_resp_data", bus.resp_data, 32'h1000 + 32'(i - 1));
         end
         tick();
      end
      bus.req_valid = 1'b0;
      @(negedge clock);
      check("stream_last_data", bus.resp_data, 32'h1007);
      drain();
      // Back-pressure: two accepts, then hold until a pop.
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_addr   = AW'(3);
      @(negedge clock);
      check("bp_ready_a", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_addr = AW'(4);
      @(negedge clock);
      check("bp_ready_b", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_addr = AW'(5);
      repeat (3) begin
         @(negedge clock);
         check("bp_ready_low", 32'(bus.req_ready), 32'd0);
         check("bp_head", bus.resp_data, 32'h1003);
      end
      tick();
      bus.resp_ready = 1'b1;
      @(negedge clock);
      check("bp_ready_pop", 32'(bus.req_ready), 32'd0);
      tick();
      @(negedge clock);
      check("bp_ready_after", 32'(bus.req_ready), 32'd1);
      check("bp_second", bus.resp_data, 32'h1004);
      tick();
      drain();
      // Same-cycle collision is forwarded byte by byte.
      write(AW'(9), 32'hAABBCCDD, 4'hF);
      bus.req_valid = 1'b1;
      bus.req_addr  = AW'(9);
      bus.wr_valid  = 1'b1;
      bus.wr_addr   = AW'(9);
      bus.wr_data   = 32'h11223344;
      bus.wr_mask   = 4'b0101;
      tick();
      bus.req_valid = 1'b0;
      bus.wr_valid  = 1'b0;
      @(negedge clock);
      check("fwd_data", bus.resp_data, 32'hAA22CC44);
      check("fwd_count_one", 32'(fwd_count), 32'd1);
      drain();
      // A write one cycle after the read must not leak into it.
      write(AW'(9), 32'hAABBCCDD, 4'hF);
      bus.req_valid = 1'b1;
      bus.req_addr  = AW'(9);
      tick();
      bus.req_valid = 1'b0;
      bus.wr_valid  = 1'b1;
      bus.wr_addr   = AW'(9);
      bus.wr_data   = '1;
      bus.wr_mask   = '1;
      @(negedge clock);
      check("late_wr_data", bus.resp_data, 32'hAABBCCDD);
      tick();
      bus.wr_valid = 1'b0;
      @(negedge clock);
      check("late_wr_fwd", 32'(fwd_count), 32'd1);
      drain();
      // Reset with one buffered response and one read in flight.
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_addr   = AW'(1);
      tick();
      bus.req_addr = AW'(2);
      tick();
      reset        = 1'b1;
      bus.req_addr = AW'(4);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = AW'(3);
      bus.wr_data  = 32'hDEADBEEF;
      bus.wr_mask  = '1;
      @(negedge clock);
      check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("mid_rst_r0_en", 32'(sram_R0_en), 32'd0);
      check("mid_rst_w0_en", 32'(sram_W0_en), 32'd0);
      tick();
      reset          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.wr_valid   = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clock);
      check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("post_rst_fwd_count", 32'(fwd_count), 32'd0);
      repeat (3) begin
         @(negedge clock);
         check("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      end
      tick();
      bus.req_valid = 1'b1;
      bus.req_addr  = AW'(3);
      tick();
      bus.req_valid = 1'b0;
      @(negedge clock);
      check("post_rst_fresh", bus.resp_data, 32'h1003);
      drain();
      // Random mixed traffic with random back-pressure.
      for (int i = 0; i < 400; i++) begin
         bus.req_valid  = 1'($urandom);
         bus.req_addr   = AW'($urandom_range(0, 15));
         bus.wr_valid   = 1'($urandom);
         bus.wr_addr    = AW'($urandom_range(0, 15));
         bus.wr_data    = $urandom;
         bus.wr_mask    = 4'($urandom);
         bus.resp_ready = $urandom_range(0, 3) != 0;
         tick();
      end
      drain();
      check("rand_fwd_count", 32'(fwd_count), 32'(fwd_exp));
      // Saturation: a collision on every cycle.
      for (int i = 0; i < 65540; i++) begin
         bus.req_valid = 1'b1;
         bus.req_addr  = AW'(i % 16);
         bus.wr_valid  = 1'b1;
         bus.wr_addr   = AW'(i % 16);
         bus.wr_data   = $urandom;
         bus.wr_mask   = 4'($urandom);
         tick();
      end
      drain();
      check("fwd_sat", 32'(fwd_count), 32'h0000FFFF);
      check("fwd_sat_model", 32'(fwd_count), 32'(fwd_exp));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
